udp_cmd_parser: RTL and testbench
=================================

# udp_cmd_parser

Command-frame parser on the read side of the UDP command FIFO. It pulls 32-bit words from the FIFO using the FIFO's `rempty` / `r_en` protocol and recognises command headers. Each command is presented as one header transaction (opcode, address, length), followed by its payload words on a separate valid/ready stream. Malformed frames are discarded and counted.

## Interface
Parameters:
- `DATA_WIDTH`, 32: FIFO word width. Fixed at 32; the header format depends on it.
- `MAX_LEN`, 256: largest legal payload length in words. Larger lengths are errors.

Ports:
- `rclk`  in  1  clock; the FIFO read clock.
- `rrst`  in  1  reset, synchronous, active-high.
- `fifo_rempty`  in  1  FIFO empty flag.
- `fifo_ren`  out  1  FIFO read enable.
- `fifo_rdata`  in  32  FIFO read data, valid the cycle after `fifo_ren` is asserted with `fifo_rempty` low.
- `cmd_valid`  out  1  header transaction valid.
- `cmd_ready`  in  1  header accepted by the consumer.
- `cmd_opcode`  out  8  command opcode.
- `cmd_addr`  out  32  command address.
- `cmd_len`  out  16  payload length in words.
- `wdata_valid`  out  1  payload word valid.
- `wdata_ready`  in  1  payload word accepted by the consumer.
- `wdata`  out  32  payload word.
- `wdata_last`  out  1  marks the final payload word.
- `err_pulse`  out  1  one-cycle pulse per detected error.
- `err_code`  out  2  error type: 1 = bad magic, 2 = length over `MAX_LEN`. Holds its last value between errors.
- `err_cnt`  out  16  total errors, saturating.

## Operation
- Frame layout:
  - word0 = {8'hA5 magic, opcode[7:0], len[15:0]}
  - word1 = addr[31:0]
  - then `len` payload words.
- FIFO fetch:
  - `fifo_ren = !fifo_rempty && !inflight && want`.
  - `inflight` is `fifo_ren` registered; the word is captured from `fifo_rdata` in the cycle `inflight` is high.
  - At most one read is outstanding, so fetch rate is at most 1 word per 2 cycles.
- States and transitions:
  - **HDR0**: `want = 1`.
    - Captured word with `[31:24] != 8'hA5`: error code 1, word dropped, stay in HDR0. This is the resync mechanism.
    - Magic OK, `len > MAX_LEN`: error code 2, `skip_cnt <= len + 1` (address plus payload), go to SKIP.
    - Otherwise latch opcode and len, go to HDR1.
  - **HDR1**: `want = 1`. On capture, latch addr, assert `cmd_valid`, go to CMD.
  - **CMD**: `want = 0`. On `cmd_valid && cmd_ready`, deassert `cmd_valid`.
    - `len == 0`: go to HDR0.
    - Otherwise `rem <= len`, go to DATA.
  - **DATA**: `want = !wdata_valid && (rem != 0)`.
    - On capture: load `wdata`, set `wdata_valid`, `rem <= rem - 1`, `wdata_last = (rem == 1)`.
    - On `wdata_valid && wdata_ready`: clear `wdata_valid`; if `wdata_last`, go to HDR0.
  - **SKIP**: `want = 1`. Each capture decrements `skip_cnt`. When a capture brings it to 0, go to HDR0.
- Counters and registers:
  - `rem` and `skip_cnt` are 17 bits wide.
  - `err_cnt` increments on every `err_pulse` and saturates at 16'hFFFF.
  - `cmd_opcode`, `cmd_addr` and `cmd_len` are registers, stable throughout CMD.
- Output stability: while `valid && !ready`, every field of that interface holds its value.
- No reads are issued in CMD. FIFO data is never consumed without being delivered, skipped or flagged.

## Timing
- Reset: state HDR0, `inflight` 0.
  - All outputs 0: `fifo_ren`, `cmd_valid`, `cmd_opcode`, `cmd_addr`, `cmd_len`, `wdata_valid`, `wdata`, `wdata_last`, `err_pulse`, `err_code`, `err_cnt`.
- Reset mid-operation:
  - Any in-flight word is discarded.
  - Partially parsed frames are abandoned.
  - `rrst` must be shared with the FIFO read side so stale words are also flushed.
- Latency, header: `fifo_ren` for word0 at cycle t, capture at t+1, `fifo_ren` for word1 at t+2, capture at t+3, `cmd_valid` high at t+4.
- Latency, payload: first payload `fifo_ren` is one cycle after the `cmd` handshake; `wdata_valid` follows 2 cycles after that.
- Error timing: `err_pulse` asserts the cycle after the offending word is captured.
- `fifo_rempty` asserted while `want` is high: no read is issued and the state holds. Underflow is impossible.
- `len` = 16'hFFFF (illegal when `MAX_LEN` = 256): SKIP discards 65536 words, with no wrap in `skip_cnt`.

## Test plan
1. FIFO holds A5010003, 00001000, D0, D1, D2; both readies held at 1.
   - Required: `cmd_valid` with op 01, addr 00001000, len 3.
   - Required: `wdata` D0, D1, D2, with `wdata_last` only on D2.
2. Zero-length frame A5020000, 00002000.
   - Required: one cmd transaction, no `wdata_valid`, return to HDR0.
   - Required: the following frame parses correctly.
3. Word 12345678 followed by a valid frame.
   - Required: exactly one `err_pulse` with `err_code` 1, `err_cnt` = 1.
   - Required: the next frame is delivered intact.
4. Oversize frame A5010101 (len 257), addr, 257 payload words, then a valid frame.
   - Required: `err_code` 2 and 258 words skipped.
   - Required: no `cmd_valid` for the bad frame; the next frame is delivered correctly.
5. Backpressure: `cmd_ready` held low 10 cycles, then `wdata_ready` toggled every cycle.
   - Required: fields stable while stalled, `fifo_ren` low during CMD, all words delivered in order.
6. Assert `rrst` one cycle during DATA, then refill the FIFO with a fresh frame.
   - Required: all outputs 0 the next cycle, then the new frame parses normally.

Source files
------------

// File: rtl/udp_cmd_parser.sv
// Command-frame parser on the read side of the UDP command FIFO.
// Splits frames into a header transaction and a payload stream; malformed frames are dropped and counted.
module udp_cmd_parser #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_LEN    = 256
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  fifo_rempty,
    output logic                  fifo_ren,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [7:0]            cmd_opcode,
    output logic [31:0]           cmd_addr,
    output logic [15:0]           cmd_len,
    output logic                  wdata_valid,
    input  logic                  wdata_ready,
    output logic [31:0]           wdata,
    output logic                  wdata_last,
    output logic                  err_pulse,
    output logic [1:0]            err_code,
    output logic [15:0]           err_cnt
);

    localparam logic [7:0]  MAGIC     = 8'hA5;
    localparam logic [16:0] MAX_LEN_W = 17'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_HDR0 = 3'd0,
        ST_HDR1 = 3'd1,
        ST_CMD  = 3'd2,
        ST_DATA = 3'd3,
        ST_SKIP = 3'd4
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic        inflight_r;
    logic        want_s;
    logic        capture_s;
    logic        magic_ok_s;
    logic        len_over_s;
    logic [15:0] hdr_len_s;
    logic        bad_magic_s;
    logic        bad_len_s;
    logic        hdr_ok_s;
    logic        cmd_hs_s;
    logic        wdata_hs_s;
    logic [16:0] rem_r;
    logic [16:0] skip_cnt_r;

    logic        cmd_valid_r;
    logic [7:0]  cmd_opcode_r;
    logic [31:0] cmd_addr_r;
    logic [15:0] cmd_len_r;
    logic        wdata_valid_r;
    logic [31:0] wdata_r;
    logic        wdata_last_r;
    logic        err_pulse_r;
    logic [1:0]  err_code_r;
    logic [15:0] err_cnt_r;

    assign capture_s  = inflight_r;
    assign hdr_len_s  = fifo_rdata[15:0];
    assign magic_ok_s = (fifo_rdata[31:24] == MAGIC);
    assign len_over_s = ({1'b0, hdr_len_s} > MAX_LEN_W);
    assign cmd_hs_s   = cmd_valid_r && cmd_ready;
    assign wdata_hs_s = wdata_valid_r && wdata_ready;

    // Single outstanding read; gated by reset so the port is quiet while the FIFO read side flushes.
    assign fifo_ren = !rrst && !fifo_rempty && !inflight_r && want_s;

    assign cmd_valid   = cmd_valid_r;
    assign cmd_opcode  = cmd_opcode_r;
    assign cmd_addr    = cmd_addr_r;
    assign cmd_len     = cmd_len_r;
    assign wdata_valid = wdata_valid_r;
    assign wdata       = wdata_r;
    assign wdata_last  = wdata_last_r;
    assign err_pulse   = err_pulse_r;
    assign err_code    = err_code_r;
    assign err_cnt     = err_cnt_r;

    // Next-state, fetch request and header classification.
    always_comb begin
        state_next_s = state_r;
        want_s       = 1'b0;
        bad_magic_s  = 1'b0;
        bad_len_s    = 1'b0;
        hdr_ok_s     = 1'b0;
        case (state_r)
            ST_HDR0: begin
                want_s = 1'b1;
                if (capture_s) begin
                    if (!magic_ok_s) begin
                        bad_magic_s  = 1'b1;
                        state_next_s = ST_HDR0;
                    end else if (len_over_s) begin
                        bad_len_s    = 1'b1;
                        state_next_s = ST_SKIP;
                    end else begin
                        hdr_ok_s     = 1'b1;
                        state_next_s = ST_HDR1;
                    end
                end else begin
                    state_next_s = ST_HDR0;
                end
            end
            ST_HDR1: begin
                want_s = 1'b1;
                if (capture_s) begin
                    state_next_s = ST_CMD;
                end else begin
                    state_next_s = ST_HDR1;
                end
            end
            ST_CMD: begin
                want_s = 1'b0;
                if (cmd_hs_s) begin
                    if (cmd_len_r == 16'd0) begin
                        state_next_s = ST_HDR0;
                    end else begin
                        state_next_s = ST_DATA;
                    end
                end else begin
                    state_next_s = ST_CMD;
                end
            end
            ST_DATA: begin
                want_s = !wdata_valid_r && (rem_r != 17'd0);
                if (wdata_hs_s && wdata_last_r) begin
                    state_next_s = ST_HDR0;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            ST_SKIP: begin
                want_s = 1'b1;
                if (capture_s && (skip_cnt_r == 17'd1)) begin
                    state_next_s = ST_HDR0;
                end else begin
                    state_next_s = ST_SKIP;
                end
            end
            default: begin
                want_s       = 1'b0;
                state_next_s = ST_HDR0;
            end
        endcase
    end

    // State and read-in-flight registers.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            state_r    <= ST_HDR0;
            inflight_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            inflight_r <= fifo_ren;
        end
    end

    // Error reporting: pulse, sticky code and saturating count.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            err_pulse_r <= 1'b0;
            err_code_r  <= 2'd0;
            err_cnt_r   <= 16'd0;
        end else begin
            err_pulse_r <= bad_magic_s || bad_len_s;
            if (bad_magic_s) begin
                err_code_r <= 2'd1;
            end else if (bad_len_s) begin
                err_code_r <= 2'd2;
            end else begin
                err_code_r <= err_code_r;
            end
            if ((bad_magic_s || bad_len_s) && (err_cnt_r != 16'hFFFF)) begin
                err_cnt_r <= err_cnt_r + 16'd1;
            end else begin
                err_cnt_r <= err_cnt_r;
            end
        end
    end

    // Header fields, payload stream and the rem/skip word counters.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            cmd_valid_r   <= 1'b0;
            cmd_opcode_r  <= 8'd0;
            cmd_addr_r    <= 32'd0;
            cmd_len_r     <= 16'd0;
            wdata_valid_r <= 1'b0;
            wdata_r       <= 32'd0;
            wdata_last_r  <= 1'b0;
            rem_r         <= 17'd0;
            skip_cnt_r    <= 17'd0;
        end else begin
            case (state_r)
                ST_HDR0: begin
                    if (hdr_ok_s) begin
                        cmd_opcode_r <= fifo_rdata[23:16];
                        cmd_len_r    <= hdr_len_s;
                    end
                    if (bad_len_s) begin
                        // address word plus every payload word must be drained
                        skip_cnt_r <= {1'b0, hdr_len_s} + 17'd1;
                    end
                end
                ST_HDR1: begin
                    if (capture_s) begin
                        cmd_addr_r  <= fifo_rdata;
                        cmd_valid_r <= 1'b1;
                    end
                end
                ST_CMD: begin
                    if (cmd_hs_s) begin
                        cmd_valid_r <= 1'b0;
                        rem_r       <= {1'b0, cmd_len_r};
                    end
                end
                ST_DATA: begin
                    if (capture_s) begin
                        wdata_r       <= fifo_rdata;
                        wdata_valid_r <= 1'b1;
                        wdata_last_r  <= (rem_r == 17'd1);
                        rem_r         <= rem_r - 17'd1;
                    end else if (wdata_hs_s) begin
                        wdata_valid_r <= 1'b0;
                        wdata_last_r  <= 1'b0;
                    end
                end
                ST_SKIP: begin
                    if (capture_s) begin
                        skip_cnt_r <= skip_cnt_r - 17'd1;
                    end
                end
                default: begin
                    cmd_valid_r   <= 1'b0;
                    wdata_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_udp_cmd_parser.sv
// Scoreboard bench for udp_cmd_parser: a queue models the FIFO, expected header,
// payload and error events are queued at stimulus time and popped on DUT handshakes.
module tb_udp_cmd_parser;

    logic        rclk = 1'b0;
    logic        rrst;
    logic        fifo_rempty;
    logic        fifo_ren;
    logic [31:0] fifo_rdata;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_opcode;
    logic [31:0] cmd_addr;
    logic [15:0] cmd_len;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [31:0] wdata;
    logic        wdata_last;
    logic        err_pulse;
    logic [1:0]  err_code;
    logic [15:0] err_cnt;

    always #5 rclk = ~rclk;

    udp_cmd_parser #(.DATA_WIDTH(32), .MAX_LEN(256)) dut (
        .rclk(rclk), .rrst(rrst),
        .fifo_rempty(fifo_rempty), .fifo_ren(fifo_ren), .fifo_rdata(fifo_rdata),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .wdata_last(wdata_last),
        .err_pulse(err_pulse), .err_code(err_code), .err_cnt(err_cnt)
    );

    typedef struct {
        logic [7:0]  op;
        logic [31:0] addr;
        logic [15:0] len;
    } cmd_t;

    cmd_t        exp_cmd_q[$];
    logic [32:0] exp_wd_q[$];
    logic [1:0]  exp_err_q[$];
    logic [31:0] fifo_q[$];

    int n_checks = 0;
    int n_bad    = 0;
    int cyc      = 0;
    int n_pops   = 0;
    int wd_hs    = 0;
    int t_ren    = -1;
    int t_cmd    = -1;
    int t_hs     = -1;
    int t_wd     = -1;
    logic wr_toggle = 1'b0;

    logic        prev_cmd_stall = 1'b0;
    logic        prev_wd_stall  = 1'b0;
    cmd_t        snap_cmd;
    logic [32:0] snap_wd;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        cmd_t        ec;
        logic [32:0] ew;
        if (rrst === 1'b0) begin
            if (prev_cmd_stall) begin
                check_eq("cmd_hold_valid", cmd_valid, 1'b1);
                check_eq("cmd_hold_op", cmd_opcode, snap_cmd.op);
                check_eq("cmd_hold_addr", cmd_addr, snap_cmd.addr);
                check_eq("cmd_hold_len", cmd_len, snap_cmd.len);
            end
            if (prev_wd_stall) begin
                check_eq("wd_hold_valid", wdata_valid, 1'b1);
                check_eq("wd_hold_data", {wdata_last, wdata}, snap_wd);
            end
            if (cmd_valid === 1'b1) begin
                check_eq("ren_in_cmd", fifo_ren, 1'b0);
            end
            if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
                check_eq("cmd_expected", exp_cmd_q.size() > 0, 1'b1);
                if (exp_cmd_q.size() > 0) begin
                    ec = exp_cmd_q.pop_front();
                    check_eq("cmd_op", cmd_opcode, ec.op);
                    check_eq("cmd_addr", cmd_addr, ec.addr);
                    check_eq("cmd_len", cmd_len, ec.len);
                end
                if (t_hs < 0) t_hs = cyc;
            end
            if (wdata_valid === 1'b1 && wdata_ready === 1'b1) begin
                wd_hs++;
                check_eq("wd_expected", exp_wd_q.size() > 0, 1'b1);
                if (exp_wd_q.size() > 0) begin
                    ew = exp_wd_q.pop_front();
                    check_eq("wd_data", wdata, ew[31:0]);
                    check_eq("wd_last", wdata_last, ew[32]);
                end
            end
            if (err_pulse === 1'b1) begin
                check_eq("err_expected", exp_err_q.size() > 0, 1'b1);
                if (exp_err_q.size() > 0) begin
                    check_eq("err_code", err_code, exp_err_q.pop_front());
                end
            end
            if (fifo_ren === 1'b1 && t_ren < 0) t_ren = cyc;
            if (cmd_valid === 1'b1 && t_cmd < 0) t_cmd = cyc;
            if (wdata_valid === 1'b1 && t_wd < 0) t_wd = cyc;
            prev_cmd_stall = (cmd_valid === 1'b1) && (cmd_ready === 1'b0);
            prev_wd_stall  = (wdata_valid === 1'b1) && (wdata_ready === 1'b0);
            snap_cmd.op    = cmd_opcode;
            snap_cmd.addr  = cmd_addr;
            snap_cmd.len   = cmd_len;
            snap_wd        = {wdata_last, wdata};
        end else begin
            prev_cmd_stall = 1'b0;
            prev_wd_stall  = 1'b0;
        end
    endtask

    // One clock: observe and serve reads at negedge, update FIFO flag and readies after posedge.
    task automatic step();
        @(negedge rclk);
        cyc++;
        monitor();
        if (fifo_ren === 1'b1) begin
            if (fifo_q.size() > 0) begin
                fifo_rdata = fifo_q.pop_front();
                n_pops++;
            end else begin
                check_eq("ren_when_empty", fifo_rempty, 1'b0);
            end
        end
        @(posedge rclk);
        #1;
        fifo_rempty = (fifo_q.size() == 0);
        if (wr_toggle) wdata_ready = ~wdata_ready;
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        fifo_rempty = 1'b0;
    endtask

    task automatic push_frame(input logic [7:0] op, input logic [31:0] addr,
                              input logic [15:0] len, input logic [31:0] base);
        cmd_t c;
        push_word({8'hA5, op, len});
        push_word(addr);
        c.op = op; c.addr = addr; c.len = len;
        exp_cmd_q.push_back(c);
        for (int i = 0; i < int'(len); i++) begin
            push_word(base + 32'(i));
            exp_wd_q.push_back({(i == int'(len) - 1), base + 32'(i)});
        end
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_cmd_q.size() == 0 && exp_wd_q.size() == 0 &&
                exp_err_q.size() == 0 && fifo_q.size() == 0) break;
            step();
        end
        check_eq({tag, "_drained"},
                 exp_cmd_q.size() + exp_wd_q.size() + exp_err_q.size() + fifo_q.size(), 0);
        repeat (4) step();
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_ren"}, fifo_ren, 1'b0);
        check_eq({tag, "_cmd"}, {cmd_valid, cmd_opcode, cmd_addr, cmd_len}, 57'd0);
        check_eq({tag, "_wd"}, {wdata_valid, wdata, wdata_last}, 34'd0);
        check_eq({tag, "_err"}, {err_pulse, err_code, err_cnt}, 19'd0);
    endtask

    initial begin
        int pops0;
        rrst        = 1'b1;
        fifo_rempty = 1'b1;
        fifo_rdata  = 32'd0;
        cmd_ready   = 1'b1;
        wdata_ready = 1'b1;
        repeat (3) step();
        rrst = 1'b0;
        step();
        check_zero("reset");

        // 1: basic frame plus header/payload latency
        push_frame(8'h01, 32'h00001000, 16'd3, 32'h000000D0);
        wait_idle("t1", 200);
        check_eq("hdr_latency", t_cmd - t_ren, 4);
        check_eq("pay_latency", t_wd - t_hs, 3);

        // 2: zero-length frame followed by a normal one
        push_frame(8'h02, 32'h00002000, 16'd0, 32'd0);
        push_frame(8'h03, 32'h00003000, 16'd2, 32'h000000E0);
        wait_idle("t2", 200);

        // 3: bad magic resync
        push_word(32'h12345678);
        exp_err_q.push_back(2'd1);
        push_frame(8'h04, 32'h00004000, 16'd1, 32'h000000F0);
        wait_idle("t3", 200);
        check_eq("t3_err_cnt", err_cnt, 16'd1);
        check_eq("t3_err_code", err_code, 2'd1);

        // 4: oversize frame skipped (header + 258 words), next frame intact
        pops0 = n_pops;
        push_word(32'hA5010101);
        push_word(32'h00005000);
        for (int i = 0; i < 257; i++) push_word(32'hBAD00000 + 32'(i));
        exp_err_q.push_back(2'd2);
        push_frame(8'h05, 32'h00006000, 16'd2, 32'h00000100);
        wait_idle("t4", 2000);
        check_eq("t4_pops", n_pops - pops0, 263);
        check_eq("t4_err_cnt", err_cnt, 16'd2);
        check_eq("t4_err_code", err_code, 2'd2);

        // 5: backpressure on both interfaces
        cmd_ready = 1'b0;
        push_frame(8'h06, 32'h00007000, 16'd4, 32'h00000200);
        for (int i = 0; i < 50; i++) begin
            if (cmd_valid === 1'b1) break;
            step();
        end
        check_eq("t5_cmd_seen", cmd_valid, 1'b1);
        repeat (10) step();
        cmd_ready = 1'b1;
        wr_toggle = 1'b1;
        wait_idle("t5", 300);
        wr_toggle   = 1'b0;
        wdata_ready = 1'b1;

        // 6: reset during DATA, then a fresh frame
        wd_hs = 0;
        push_frame(8'h07, 32'h00008000, 16'd4, 32'h00000300);
        for (int i = 0; i < 100; i++) begin
            if (wd_hs > 0) break;
            step();
        end
        check_eq("t6_in_data", wd_hs > 0, 1'b1);
        rrst = 1'b1;
        step();
        rrst = 1'b0;
        fifo_q.delete();
        exp_cmd_q.delete();
        exp_wd_q.delete();
        exp_err_q.delete();
        fifo_rempty = 1'b1;
        #1;
        check_zero("t6_rst");
        push_frame(8'h08, 32'h00009000, 16'd2, 32'h00000400);
        wait_idle("t6", 200);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
